// File: rtl/tiny8_types.sv
// Shared types for the tiny8 core: opcodes, ALU ops and control FSM states,
// plus the bundle of control outputs driven into the datapath.
package tiny8_types;

  // Decoded opcode from the datapath IR. Encoding 3'd7 is deliberately left
  // unassigned so that it decodes as an illegal instruction.
  typedef enum logic [2:0] {
    op_addi = 3'd0,
    op_inc  = 3'd1,
    op_acc  = 3'd2,
    op_ldr  = 3'd3,
    op_str  = 3'd4,
    op_jmp  = 3'd5,
    op_halt = 3'd6
  } tiny8_opcode;

  typedef enum logic [1:0] {
    alu_add  = 2'd0,
    alu_sub  = 2'd1,
    alu_and  = 2'd2,
    alu_pass = 2'd3
  } tiny8_aluop;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    LDR    = 3'd3,
    STR    = 3'd4,
    HALT   = 3'd5,
    FAULT  = 3'd6
  } tiny8_ctrl_state;

  // Width of the memory-wait counter; the timeout limit must fit in it.
  localparam int unsigned WAIT_W = 8;

  // addrmux_sel encodings
  localparam logic [1:0] ADDR_PC = 2'd0;
  localparam logic [1:0] ADDR_RS = 2'd1;
  localparam logic [1:0] ADDR_RD = 2'd2;

  // Everything the FSM drives into the datapath and memory.
  typedef struct packed {
    logic       load_pc;
    logic       load_ir;
    logic       load_acc;
    logic       load_rs;
    logic       load_rd;
    tiny8_aluop aluop;
    logic       pcmux_sel;
    logic [1:0] addrmux_sel;
    logic       alumux1_sel;
    logic       alumux2_sel;
    logic       regfilemux_sel;
    logic       mem_read;
    logic       mem_write;
    logic       halted;
    logic       fault;
  } tiny8_ctrl_t;

  // Idle value: nothing loaded, no strobes, selects at 0, ALU adding.
  localparam tiny8_ctrl_t CTRL_IDLE = '{
    load_pc: 1'b0, load_ir: 1'b0, load_acc: 1'b0, load_rs: 1'b0,
    load_rd: 1'b0, aluop: alu_add, pcmux_sel: 1'b0, addrmux_sel: ADDR_PC,
    alumux1_sel: 1'b0, alumux2_sel: 1'b0, regfilemux_sel: 1'b0,
    mem_read: 1'b0, mem_write: 1'b0, halted: 1'b0, fault: 1'b0
  };

  // States that hold a memory strobe and wait on mem_resp.
  function automatic logic is_mem_state(tiny8_ctrl_state s);
    return (s == FETCH) || (s == LDR) || (s == STR);
  endfunction

endpackage

// File: rtl/tiny8_wait_timer.sv
// Memory-wait counter. Counts cycles spent in a memory state without a
// response and flags the cycle in which the wait budget is exhausted.
module tiny8_wait_timer
  import tiny8_types::*;
#(
  parameter int unsigned LIMIT = 255  // 1..255 wait cycles before timeout
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy_i,     // FSM is in a memory state this cycle
  input  logic resp_i,     // memory response this cycle
  output logic timeout_o   // last allowed wait cycle passed without response
);

  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(LIMIT - 1);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  // The count shows how many wait cycles already elapsed, so the LIMIT-th
  // wait cycle is the one where cnt_q == LIMIT-1. A response in that same
  // cycle suppresses the timeout.
  assign timeout_o = busy_i && !resp_i && (cnt_q == LAST);

  // Clear whenever a memory state is left (response, timeout) or not
  // occupied, so every entry into FETCH/LDR/STR starts from zero.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!busy_i || resp_i || timeout_o) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tiny8_control.sv
// Multicycle control FSM for the tiny8 core. Sequences fetch, decode,
// execute and memory access, drives every datapath load/select and the
// memory strobes, and parks in HALT or FAULT until reset.
module tiny8_control
  import tiny8_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255  // 1..255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  tiny8_opcode opcode,
  input  logic        mem_resp,
  output logic        load_pc,
  output logic        load_ir,
  output logic        load_acc,
  output logic        load_rs,
  output logic        load_rd,
  output tiny8_aluop  aluop,
  output logic        pcmux_sel,
  output logic [1:0]  addrmux_sel,
  output logic        alumux1_sel,
  output logic        alumux2_sel,
  output logic        regfilemux_sel,
  output logic        mem_read,
  output logic        mem_write,
  output logic        halted,
  output logic        fault
);

  tiny8_ctrl_state state_q, state_d;
  tiny8_ctrl_t     ctrl;
  logic            busy;
  logic            timeout;

  assign busy = is_mem_state(state_q);

  tiny8_wait_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .busy_i   (busy),
    .resp_i   (mem_resp),
    .timeout_o(timeout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic. A response always beats a timeout in the same cycle;
  // mem_resp in non-memory states has no effect.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: begin
        if (mem_resp)     state_d = DECODE;
        else if (timeout) state_d = FAULT;
      end
      DECODE: begin
        case (opcode)
          op_addi, op_inc, op_acc, op_jmp: state_d = EXEC;
          op_ldr:                          state_d = LDR;
          op_str:                          state_d = STR;
          op_halt:                         state_d = HALT;
          default:                         state_d = FAULT;
        endcase
      end
      EXEC: state_d = FETCH;
      LDR, STR: begin
        if (mem_resp)     state_d = FETCH;
        else if (timeout) state_d = FAULT;
      end
      HALT:    state_d = HALT;
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase
  end

  // Output decode from state and mem_resp. Held idle while rst_n is low so
  // an access in flight loses its strobe immediately, not at the next edge.
  always_comb begin
    ctrl = CTRL_IDLE;
    if (rst_n) begin
      unique case (state_q)
        FETCH: begin
          ctrl.mem_read    = 1'b1;
          ctrl.addrmux_sel = ADDR_PC;
          if (mem_resp) begin
            // IR captures the instruction while pc advances to pc+1.
            ctrl.load_ir   = 1'b1;
            ctrl.load_pc   = 1'b1;
            ctrl.pcmux_sel = 1'b0;
          end
        end
        DECODE: ;
        EXEC: begin
          case (opcode)
            op_addi: begin
              ctrl.alumux1_sel    = 1'b0;
              ctrl.alumux2_sel    = 1'b1;
              ctrl.regfilemux_sel = 1'b0;
              ctrl.load_rd        = 1'b1;
            end
            op_inc: begin
              ctrl.alumux1_sel = 1'b0;
              ctrl.alumux2_sel = 1'b0;
              ctrl.load_rs     = 1'b1;
            end
            op_acc: begin
              ctrl.alumux1_sel = 1'b1;
              ctrl.alumux2_sel = 1'b0;
              ctrl.load_acc    = 1'b1;
            end
            op_jmp: begin
              // pc already holds pc+1 from FETCH; offset is relative to it.
              ctrl.pcmux_sel = 1'b1;
              ctrl.load_pc   = 1'b1;
            end
            default: ;
          endcase
        end
        LDR: begin
          ctrl.mem_read    = 1'b1;
          ctrl.addrmux_sel = ADDR_RS;
          if (mem_resp) begin
            ctrl.regfilemux_sel = 1'b1;
            ctrl.load_rd        = 1'b1;
          end
        end
        STR: begin
          ctrl.mem_write   = 1'b1;
          ctrl.addrmux_sel = ADDR_RD;
        end
        HALT:    ctrl.halted = 1'b1;
        FAULT:   ctrl.fault  = 1'b1;
        default: ctrl.fault  = 1'b1;
      endcase
    end
  end

  assign load_pc        = ctrl.load_pc;
  assign load_ir        = ctrl.load_ir;
  assign load_acc       = ctrl.load_acc;
  assign load_rs        = ctrl.load_rs;
  assign load_rd        = ctrl.load_rd;
  assign aluop          = ctrl.aluop;
  assign pcmux_sel      = ctrl.pcmux_sel;
  assign addrmux_sel    = ctrl.addrmux_sel;
  assign alumux1_sel    = ctrl.alumux1_sel;
  assign alumux2_sel    = ctrl.alumux2_sel;
  assign regfilemux_sel = ctrl.regfilemux_sel;
  assign mem_read       = ctrl.mem_read;
  assign mem_write      = ctrl.mem_write;
  assign halted         = ctrl.halted;
  assign fault          = ctrl.fault;

endmodule

// File: tb/tb_tiny8_control.sv
// Directed bench for tiny8_control: a per-cycle vector table for the normal
// instruction flow plus hand sequences for reset, timeout, halt and illegal.
module tb_tiny8_control;
  import tiny8_types::*;

  logic        clk = 1'b0;
  logic        rst_n;
  tiny8_opcode opcode;
  logic        mem_resp;
  logic        load_pc, load_ir, load_acc, load_rs, load_rd;
  tiny8_aluop  aluop;
  logic        pcmux_sel;
  logic [1:0]  addrmux_sel;
  logic        alumux1_sel, alumux2_sel, regfilemux_sel;
  logic        mem_read, mem_write, halted, fault;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  tiny8_control #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_resp(mem_resp),
    .load_pc(load_pc), .load_ir(load_ir), .load_acc(load_acc),
    .load_rs(load_rs), .load_rd(load_rd), .aluop(aluop),
    .pcmux_sel(pcmux_sel), .addrmux_sel(addrmux_sel),
    .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel),
    .regfilemux_sel(regfilemux_sel), .mem_read(mem_read),
    .mem_write(mem_write), .halted(halted), .fault(fault)
  );

  // Observed vector: {lpc,lir,lacc,lrs,lrd}_pcmux_addr[1:0]_{am1,am2,rfm}_{rd,wr}_{halt,fault}
  logic [14:0] obs;
  assign obs = {load_pc, load_ir, load_acc, load_rs, load_rd, pcmux_sel,
                addrmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel,
                mem_read, mem_write, halted, fault};

  localparam logic [14:0] O_NONE  = 15'b00000_0_00_000_00_00;
  localparam logic [14:0] O_FETCH = 15'b00000_0_00_000_10_00;
  localparam logic [14:0] O_FRESP = 15'b11000_0_00_000_10_00;
  localparam logic [14:0] O_ADDI  = 15'b00001_0_00_010_00_00;
  localparam logic [14:0] O_INC   = 15'b00010_0_00_000_00_00;
  localparam logic [14:0] O_ACC   = 15'b00100_0_00_100_00_00;
  localparam logic [14:0] O_JMP   = 15'b10000_1_00_000_00_00;
  localparam logic [14:0] O_LDRW  = 15'b00000_0_01_000_10_00;
  localparam logic [14:0] O_LDRR  = 15'b00001_0_01_001_10_00;
  localparam logic [14:0] O_STR   = 15'b00000_0_10_000_01_00;
  localparam logic [14:0] O_HALT  = 15'b00000_0_00_000_00_10;
  localparam logic [14:0] O_FAULT = 15'b00000_0_00_000_00_01;

  typedef struct {
    tiny8_opcode op;
    logic        resp;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl[29];

  task automatic check(input string nm, input logic [14:0] exp);
    logic [16:0] act, req;
    act = {aluop, obs};
    req = {alu_add, exp};
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %b required %b", nm, act, req);
    end
  endtask

  // Called at posedge+1: drive inputs, sample mid-cycle, advance one cycle.
  task automatic step(input string nm, input tiny8_opcode op, input logic resp,
                      input logic [14:0] exp);
    opcode   = op;
    mem_resp = resp;
    #2;
    check(nm, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    mem_resp = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    tiny8_opcode bad_op;
    logic [2:0]  bad_raw;

    // addi, immediate memory
    tbl[0]  = '{op_addi, 1'b1, O_FRESP};
    tbl[1]  = '{op_addi, 1'b0, O_NONE};
    tbl[2]  = '{op_addi, 1'b0, O_ADDI};
    // inc
    tbl[3]  = '{op_inc,  1'b1, O_FRESP};
    tbl[4]  = '{op_inc,  1'b0, O_NONE};
    tbl[5]  = '{op_inc,  1'b0, O_INC};
    // acc
    tbl[6]  = '{op_acc,  1'b1, O_FRESP};
    tbl[7]  = '{op_acc,  1'b0, O_NONE};
    tbl[8]  = '{op_acc,  1'b0, O_ACC};
    // ldr: one fetch wait, then 3 wait cycles on the data access
    tbl[9]  = '{op_ldr,  1'b0, O_FETCH};
    tbl[10] = '{op_ldr,  1'b1, O_FRESP};
    tbl[11] = '{op_ldr,  1'b0, O_NONE};
    tbl[12] = '{op_ldr,  1'b0, O_LDRW};
    tbl[13] = '{op_ldr,  1'b0, O_LDRW};
    tbl[14] = '{op_ldr,  1'b0, O_LDRW};
    tbl[15] = '{op_ldr,  1'b1, O_LDRR};
    // str with a stray response during DECODE (ignored)
    tbl[16] = '{op_str,  1'b1, O_FRESP};
    tbl[17] = '{op_str,  1'b1, O_NONE};
    tbl[18] = '{op_str,  1'b0, O_STR};
    tbl[19] = '{op_str,  1'b1, O_STR};
    // jmp with a stray response during EXEC (ignored)
    tbl[20] = '{op_jmp,  1'b1, O_FRESP};
    tbl[21] = '{op_jmp,  1'b0, O_NONE};
    tbl[22] = '{op_jmp,  1'b1, O_JMP};
    // fetch answered on the 4th wait cycle: response beats the timeout
    tbl[23] = '{op_addi, 1'b0, O_FETCH};
    tbl[24] = '{op_addi, 1'b0, O_FETCH};
    tbl[25] = '{op_addi, 1'b0, O_FETCH};
    tbl[26] = '{op_addi, 1'b1, O_FRESP};
    tbl[27] = '{op_addi, 1'b0, O_NONE};
    tbl[28] = '{op_addi, 1'b0, O_ADDI};

    // Reset state, then asynchronous reset during a FETCH access.
    rst_n    = 1'b0;
    opcode   = op_addi;
    mem_resp = 1'b0;
    #3;
    check("reset_hold", O_NONE);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #2;
    check("fetch_after_reset", O_FETCH);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_drop", O_NONE);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table-driven normal flow.
    for (int i = 0; i < 29; i++)
      step($sformatf("vec%0d", i), tbl[i].op, tbl[i].resp, tbl[i].exp);

    // str timeout: mem_write for exactly 4 cycles, then sticky fault.
    do_reset();
    step("to_fetch", op_str, 1'b1, O_FRESP);
    step("to_decode", op_str, 1'b0, O_NONE);
    for (int i = 0; i < 4; i++) step($sformatf("to_wait%0d", i), op_str, 1'b0, O_STR);
    for (int i = 0; i < 20; i++)
      step($sformatf("to_fault%0d", i), op_str, logic'(i[0]), O_FAULT);

    // jmp then halt: halted sticky, no strobes even with mem_resp pulses.
    do_reset();
    step("jh_fetch", op_jmp, 1'b1, O_FRESP);
    step("jh_decode", op_jmp, 1'b0, O_NONE);
    step("jh_exec", op_jmp, 1'b0, O_JMP);
    step("halt_fetch", op_halt, 1'b1, O_FRESP);
    step("halt_decode", op_halt, 1'b0, O_NONE);
    for (int i = 0; i < 20; i++)
      step($sformatf("halt_hold%0d", i), op_halt, logic'(i[0]), O_HALT);

    // Illegal encoding: fault instead of halt.
    do_reset();
    bad_raw = 3'd7;
    bad_op  = tiny8_opcode'(bad_raw);
    step("ill_fetch", bad_op, 1'b1, O_FRESP);
    step("ill_decode", bad_op, 1'b0, O_NONE);
    for (int i = 0; i < 5; i++)
      step($sformatf("ill_fault%0d", i), bad_op, logic'(i[0]), O_FAULT);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
